// File: rtl/tspi_cmd_sched_pkg.sv
// Shared types and constants for the TSPI command scheduler.
package tspi_cmd_sched_pkg;

  localparam int TSPI_CNT_W = 8;
  localparam int TSPI_LEN_W = 6;
  // The counter registers new_req once before it can act on a strobe.
  localparam int NEW_REQ_MIN_HOLD = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  typedef struct packed {
    sched_state_e state;
    logic         cnt_early_end;
  } sched_dbg_t;

endpackage

// File: rtl/tspi_rr_arb.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module tspi_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_any
);

  logic [IW-1:0] k;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    k       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IW'((int'(ptr) + i) % NUM_REQ);
      if (!gnt_any && valid[k]) begin
        gnt_any   = 1'b1;
        gnt_oh[k] = 1'b1;
        gnt_idx   = k;
      end
    end
  end

endmodule

// File: rtl/tspi_cmd_sched.sv
// Round-robin command scheduler feeding the TSPI bit/command counter,
// with watchdog, abort and per-command done/error reporting.
module tspi_cmd_sched
  import tspi_cmd_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = TSPI_CNT_W,
  parameter int LEN_W   = TSPI_LEN_W,
  parameter int TO_W    = 12
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ-1:0][CNT_W-1:0]     req_cnt_i,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]     req_len_i,
  input  logic                              bit_strobe_i,
  input  logic                              ctr_last_bit_i,
  input  logic [CNT_W-1:0]                  ctr_cnt_cmd_i,
  output logic                              ctr_new_req_o,
  output logic [CNT_W-1:0]                  ctr_cnt_cmd_o,
  output logic [LEN_W-1:0]                  ctr_len_cmd_o,
  input  logic                              abort_i,
  output logic                              busy_o,
  output logic [$clog2(NUM_REQ)-1:0]        active_id_o,
  output logic                              done_o,
  output logic                              done_err_o,
  output logic [$clog2(NUM_REQ)-1:0]        done_id_o,
  output sched_dbg_t                        dbg_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [TO_W-1:0] WDOG_MAX = '1;
  localparam logic [1:0] HOLD_MIN = 2'(NEW_REQ_MIN_HOLD);

  sched_state_e     state;
  logic [IW-1:0]    rr_ptr, lat_id, done_id_q;
  logic [CNT_W-1:0] lat_cnt, remaining;
  logic [LEN_W-1:0] lat_len;
  logic [TO_W-1:0]  wdog, wdog_nxt;
  logic [1:0]       hold;
  logic             done_q, done_err_q;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               timeout, last_evt, load_go, fail;

  tspi_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .valid   (req_valid_i),
    .ptr     (rr_ptr),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    wdog_nxt = bit_strobe_i ? '0 : ((wdog == WDOG_MAX) ? wdog : wdog + 1'b1);
    timeout  = !bit_strobe_i && (wdog_nxt == WDOG_MAX);
    last_evt = bit_strobe_i && ctr_last_bit_i;
    load_go  = bit_strobe_i && (hold >= HOLD_MIN);
    fail     = abort_i || timeout;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lat_id     <= '0;
      lat_cnt    <= '0;
      lat_len    <= '0;
      remaining  <= '0;
      wdog       <= '0;
      hold       <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      done_id_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            lat_cnt <= req_cnt_i[gnt_idx];
            lat_len <= req_len_i[gnt_idx];
            lat_id  <= gnt_idx;
            wdog    <= '0;
            hold    <= 2'd1;
            if (req_cnt_i[gnt_idx] == '0) begin
              state     <= DONE;
              done_q    <= 1'b1;
              done_id_q <= gnt_idx;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (fail) begin
            state      <= DONE;
            done_q     <= 1'b1;
            done_err_q <= 1'b1;
            done_id_q  <= lat_id;
          end else if (load_go) begin
            state     <= RUN;
            remaining <= lat_cnt;
            wdog      <= '0;
          end else begin
            wdog <= wdog_nxt;
            if (hold < HOLD_MIN) hold <= hold + 1'b1;
          end
        end
        RUN: begin
          // Abort and timeout outrank a coincident final last-bit event.
          if (fail) begin
            state      <= DONE;
            done_q     <= 1'b1;
            done_err_q <= 1'b1;
            done_id_q  <= lat_id;
          end else if (last_evt && remaining == CNT_W'(1)) begin
            state     <= DONE;
            done_q    <= 1'b1;
            done_id_q <= lat_id;
          end else begin
            wdog <= wdog_nxt;
            if (last_evt) remaining <= remaining - 1'b1;
          end
        end
        DONE: begin
          rr_ptr <= (lat_id == IW'(NUM_REQ - 1)) ? '0 : lat_id + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake: a command is taken when req_valid_i[g] && req_ready_o[g];
  // ready is a one-cycle pulse only in IDLE and only to the arbitration winner.
  assign req_ready_o   = (state == IDLE) ? gnt_oh : '0;
  assign ctr_new_req_o = (state == LOAD) && !abort_i;
  assign ctr_cnt_cmd_o = lat_cnt;
  assign ctr_len_cmd_o = lat_len;
  assign busy_o        = (state == LOAD) || (state == RUN);
  assign active_id_o   = lat_id;
  assign done_o        = done_q;
  assign done_err_o    = done_err_q;
  assign done_id_o     = done_id_q;

  // Counter claims nothing left while our own count still expects more frames.
  assign dbg_o.state         = state;
  assign dbg_o.cnt_early_end = (state == RUN) && (ctr_cnt_cmd_i == '0) && (remaining > CNT_W'(1));

endmodule

// File: tb/tb_tspi_cmd_sched.sv
// Directed bench for tspi_cmd_sched: single command, round-robin, zero count,
// abort, watchdog timeout and mid-command reset.
module tb_tspi_cmd_sched;
  import tspi_cmd_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = 6;
  localparam int TO_W    = 4;

  logic                          clk_i = 1'b0;
  logic                          rst_i;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ-1:0][CNT_W-1:0] req_cnt_i;
  logic [NUM_REQ-1:0][LEN_W-1:0] req_len_i;
  logic                          bit_strobe_i;
  logic                          ctr_last_bit_i;
  logic [CNT_W-1:0]              ctr_cnt_cmd_i;
  logic                          ctr_new_req_o;
  logic [CNT_W-1:0]              ctr_cnt_cmd_o;
  logic [LEN_W-1:0]              ctr_len_cmd_o;
  logic                          abort_i;
  logic                          busy_o;
  logic [1:0]                    active_id_o;
  logic                          done_o;
  logic                          done_err_o;
  logic [1:0]                    done_id_o;
  sched_dbg_t                    dbg_o;

  int checks = 0;
  int errors = 0;

  tspi_cmd_sched #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .LEN_W(LEN_W), .TO_W(TO_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_cnt_i      (req_cnt_i),
    .req_len_i      (req_len_i),
    .bit_strobe_i   (bit_strobe_i),
    .ctr_last_bit_i (ctr_last_bit_i),
    .ctr_cnt_cmd_i  (ctr_cnt_cmd_i),
    .ctr_new_req_o  (ctr_new_req_o),
    .ctr_cnt_cmd_o  (ctr_cnt_cmd_o),
    .ctr_len_cmd_o  (ctr_len_cmd_o),
    .abort_i        (abort_i),
    .busy_o         (busy_o),
    .active_id_o    (active_id_o),
    .done_o         (done_o),
    .done_err_o     (done_err_o),
    .done_id_o      (done_id_o),
    .dbg_o          (dbg_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives strobes from the LOAD entry cycle (c=0) until done_o or max_cyc.
  task automatic run_strobes(input int max_cyc, input int period, input int last_every,
                             output int done_cyc, output int nreq, output int last_run,
                             output int rdy_busy, output logic err, output logic [1:0] id);
    int sc;
    logic s;
    sc = 0; done_cyc = -1; nreq = 0; last_run = 0; rdy_busy = 0; err = 1'bx; id = 2'bxx;
    for (int c = 0; c < max_cyc; c++) begin
      s = (period > 0) && (c % period == period - 1);
      if (s) sc++;
      bit_strobe_i   = s;
      ctr_last_bit_i = s && (sc % last_every == 0);
      #1;
      if (ctr_new_req_o) nreq++;
      if (busy_o && req_ready_o != '0) rdy_busy++;
      if (dbg_o.state == RUN && bit_strobe_i && ctr_last_bit_i) last_run++;
      if (done_o) begin
        done_cyc = c; err = done_err_o; id = done_id_o;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    bit_strobe_i   = 1'b0;
    ctr_last_bit_i = 1'b0;
  endtask

  int   dc, nr, lr, rb;
  logic e;
  logic [1:0] id;
  logic [3:0] order [6];

  initial begin
    rst_i = 1'b1; req_valid_i = '0; req_cnt_i = '0; req_len_i = '0;
    bit_strobe_i = 1'b0; ctr_last_bit_i = 1'b0; ctr_cnt_cmd_i = '0; abort_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;
    #1;
    chk("rst_state", 32'(dbg_o.state), 32'(IDLE));
    chk("rst_busy", busy_o, 0);
    chk("rst_new_req", ctr_new_req_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_done_err", done_err_o, 0);
    chk("rst_done_id", done_id_o, 0);
    chk("rst_active_id", active_id_o, 0);
    chk("rst_cnt_cmd", ctr_cnt_cmd_o, 0);
    chk("rst_len_cmd", ctr_len_cmd_o, 0);
    chk("rst_ready", req_ready_o, 0);

    // Single request: cnt=3 len=8, strobe every 4 clk, last bit every 8th strobe
    req_cnt_i[0] = 8'd3; req_len_i[0] = 6'd8; req_valid_i = 4'b0001;
    #1;
    chk("single_ready", req_ready_o, 4'b0001);
    step();
    req_valid_i = '0;
    chk("single_load_state", 32'(dbg_o.state), 32'(LOAD));
    chk("single_cnt_cmd", ctr_cnt_cmd_o, 3);
    chk("single_len_cmd", ctr_len_cmd_o, 8);
    chk("single_busy", busy_o, 1);
    run_strobes(200, 4, 8, dc, nr, lr, rb, e, id);
    chk("single_done_cyc", dc, 96);
    chk("single_new_req_cycles", nr, 4);
    chk("single_last_events", lr, 3);
    chk("single_done_err", e, 0);
    chk("single_done_id", id, 0);
    step();
    chk("single_busy_after", busy_o, 0);
    chk("single_done_after", done_o, 0);
    chk("single_len_hold", ctr_len_cmd_o, 8);

    // Round-robin from pointer 0
    rst_i = 1'b1; step(); rst_i = 1'b0;
    req_cnt_i = {8'd1, 8'd1, 8'd1, 8'd1};
    req_len_i = {6'd4, 6'd4, 6'd4, 6'd4};
    req_valid_i = 4'b1111;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001; order[5] = 4'b0100;
    for (int n = 0; n < 6; n++) begin
      if (n == 4) req_valid_i = 4'b0101;
      #1;
      chk($sformatf("rr_ready_%0d", n), req_ready_o, order[n]);
      step();
      req_valid_i = req_valid_i & ~order[n];
      run_strobes(20, 2, 1, dc, nr, lr, rb, e, id);
      chk($sformatf("rr_done_cyc_%0d", n), dc, 4);
      chk($sformatf("rr_done_id_%0d", n), {28'd0, order[n]}, 32'(1) << id);
      chk($sformatf("rr_err_%0d", n), e, 0);
      chk($sformatf("rr_ready_busy_%0d", n), rb, 0);
      step();
    end

    // Zero count on req1 (pointer now 3)
    req_cnt_i[1] = 8'd0; req_valid_i = 4'b0010;
    #1;
    chk("zero_ready", req_ready_o, 4'b0010);
    step();
    req_valid_i = '0;
    chk("zero_done", done_o, 1);
    chk("zero_err", done_err_o, 0);
    chk("zero_id", done_id_o, 1);
    chk("zero_new_req", ctr_new_req_o, 0);
    chk("zero_busy", busy_o, 0);
    step();
    chk("zero_done_after", done_o, 0);
    chk("zero_new_req_after", ctr_new_req_o, 0);

    // Abort in RUN with remaining=2, coincident with a last-bit strobe (pointer 2)
    req_cnt_i[3] = 8'd3; req_valid_i = 4'b1000;
    #1;
    chk("abort_ready", req_ready_o, 4'b1000);
    step();
    req_valid_i = '0;
    run_strobes(5, 2, 1, dc, nr, lr, rb, e, id);
    chk("abort_no_early_done", dc, -1);
    chk("abort_pre_state", 32'(dbg_o.state), 32'(RUN));
    bit_strobe_i = 1'b1; ctr_last_bit_i = 1'b1; abort_i = 1'b1;
    step();
    bit_strobe_i = 1'b0; ctr_last_bit_i = 1'b0; abort_i = 1'b0;
    chk("abort_done", done_o, 1);
    chk("abort_err", done_err_o, 1);
    chk("abort_id", done_id_o, 3);
    chk("abort_busy", busy_o, 0);
    step();

    // Pointer advanced to 0: valid {3,0} must pick 0; then watchdog timeout
    req_cnt_i[0] = 8'd5; req_valid_i = 4'b1001;
    #1;
    chk("abort_rr_advance", req_ready_o, 4'b0001);
    step();
    req_valid_i = '0;
    run_strobes(40, 0, 1, dc, nr, lr, rb, e, id);
    chk("timeout_done_cyc", dc, 15);
    chk("timeout_err", e, 1);
    chk("timeout_id", id, 0);
    step();

    // Reset in the middle of RUN (pointer 1)
    req_cnt_i[2] = 8'd4; req_valid_i = 4'b0100;
    #1;
    chk("rst_mid_ready", req_ready_o, 4'b0100);
    step();
    req_valid_i = '0;
    run_strobes(4, 2, 1, dc, nr, lr, rb, e, id);
    chk("rst_mid_pre_state", 32'(dbg_o.state), 32'(RUN));
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst_mid_state", 32'(dbg_o.state), 32'(IDLE));
    chk("rst_mid_done", done_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_new_req", ctr_new_req_o, 0);
    chk("rst_mid_len", ctr_len_cmd_o, 0);
    chk("rst_mid_cnt", ctr_cnt_cmd_o, 0);
    chk("rst_mid_active", active_id_o, 0);
    req_valid_i = 4'b0101;
    #1;
    chk("rst_mid_ptr0", req_ready_o, 4'b0001);
    step();
    req_valid_i = '0;
    chk("rst_mid_no_done", done_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tspi_cmd_sched.md
Name: tspi_cmd_sched

Overview:
- Command scheduler in front of the TSPI bit/command counter.
- Arbitrates round-robin between NUM_REQ requesters, each submitting a command (repeat count plus bit length).
- Loads the winner into the counter and tracks completion against the counter's last-bit indication.
- Reports per-command done/error status to the requester side; sits between register/DMA front ends and the TSPI datapath.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- CNT_W, 8: width of command repeat count.
- LEN_W, 6: width of command bit length.
- TO_W, 12: width of watchdog counter, measured in clk_i cycles without a bit strobe.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester command valid.
- req_ready_o  out  NUM_REQ  one-hot accept pulse.
- req_cnt_i  in  NUM_REQ x CNT_W  repeat count per requester.
- req_len_i  in  NUM_REQ x LEN_W  bit length per requester.
- bit_strobe_i  in  1  one-cycle pulse per TSPI clock rising edge (same edge the counter advances on).
- ctr_last_bit_i  in  1  counter last-bit flag.
- ctr_cnt_cmd_i  in  CNT_W  counter's remaining count.
- ctr_new_req_o  out  1  load request to counter.
- ctr_cnt_cmd_o  out  CNT_W  count to load.
- ctr_len_cmd_o  out  LEN_W  length to load (held for whole command).
- abort_i  in  1  software abort of active command.
- busy_o  out  1  command in LOAD or RUN.
- active_id_o  out  $clog2(NUM_REQ)  granted requester index.
- done_o  out  1  completion pulse.
- done_err_o  out  1  qualifies done_o: 1 = aborted or timed out.
- done_id_o  out  $clog2(NUM_REQ)  requester whose command finished.

Behaviour:
- Reset: state IDLE; rr pointer 0; all outputs 0; latched cnt/len 0; watchdog 0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req_valid_i, grant the first valid index at or after the rr pointer (wrap modulo NUM_REQ).
  - Pulse req_ready_o[g] in the same cycle; latch cnt, len and g.
  - If cnt==0: go to DONE directly with err=0 (no counter load). Otherwise go to LOAD.
  - No grant while not IDLE; req_ready_o is always 0 outside IDLE.
- LOAD:
  - ctr_new_req_o=1; ctr_cnt_cmd_o and ctr_len_cmd_o hold the latched values.
  - The counter registers new_req internally one cycle and loads only on a strobe, so LOAD exits to RUN on the first bit_strobe_i arriving when ctr_new_req_o has been high ≥2 cycles.
  - ctr_new_req_o drops on entry to RUN.
- RUN:
  - Local remaining counter starts at latched cnt; it decrements on bit_strobe_i & ctr_last_bit_i.
  - When that event occurs with remaining==1, go to DONE with err=0.
  - ctr_cnt_cmd_i is used only as a check: busy_o stays 1 until the local count completes, regardless of ctr_cnt_cmd_i.
- DONE:
  - One cycle: done_o=1, done_id_o=g, done_err_o per cause.
  - rr pointer becomes g+1 mod NUM_REQ; return to IDLE. First possible new grant is the following cycle.
- Watchdog:
  - In LOAD/RUN, counts clk_i cycles since the last bit_strobe_i; cleared by each strobe and on state entry.
  - Saturation at 2^TO_W-1 forces DONE with err=1.
- abort_i in LOAD/RUN: next cycle is DONE with err=1; ctr_new_req_o deasserts immediately. abort_i in IDLE or DONE is ignored.
- Simultaneous-event priority, highest first: abort, timeout, normal completion. Error wins if all coincide.
- ctr_len_cmd_o holds its value through IDLE after completion (no glitch to the counter).
- busy_o=1 exactly in LOAD and RUN. active_id_o is valid while busy_o=1.
- Synchronous reset mid-command returns to IDLE on the next edge with no done_o pulse.

Decomposition:
- tspi_pkg additions:
  - sched_state_e (IDLE, LOAD, RUN, DONE).
  - Constants TSPI_CNT_W=8, TSPI_LEN_W=6 used as parameter defaults.
  - Localparam for minimum new_req hold (2).
- One sub-module: tspi_rr_arb. Purely combinational grant from valid vector and pointer, plus a one-hot/index output; the pointer register lives in the parent.

Test Plan:
- Single request: req0 cnt=3 len=8; strobe every 4 clk; last_bit every 8th strobe.
  - Required: ctr_new_req_o high ≥2 cycles; RUN entered; exactly 3 last-bit events.
  - Then done_o=1, done_id_o=0, done_err_o=0; busy_o low the next cycle.
- Round-robin: req0..req3 all valid, cnt=1 each.
  - Required: grant order 0,1,2,3; then with req0 and req2 re-valid, order 0,2. No req_ready_o while busy.
- Zero count: req1 cnt=0.
  - Required: req_ready_o[1] pulse, next cycle done_o=1, err=0; ctr_new_req_o never asserted.
- Abort: abort_i raised in RUN with remaining=2, on the same cycle as a last-bit strobe.
  - Required: done_o with done_err_o=1; rr pointer advances.
- Timeout: TO_W=4, no strobes after LOAD.
  - Required: done_err_o=1 done pulse 15 cycles after the last strobe/entry.
- Reset mid-RUN: rst_i for 1 cycle.
  - Required: all outputs 0, state IDLE, no done_o; next grant starts at index 0.
